// File: rtl/ascii_stream_arbiter_pkg.sv
// Shared character constants, the acceptance rule and the FIFO entry layout
// for the ASCII character path.
package ascii_pkg;

    localparam logic [7:0] ASCII_BS        = 8'h08;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

    // Source field is sized for the largest supported source count (8).
    typedef struct packed {
        logic [2:0] src;
        logic [7:0] data;
    } fifo_entry_t;

    function automatic logic is_accepted_char(input logic [7:0] c);
        return ((c >= ASCII_PRINT_MIN) && (c <= ASCII_PRINT_MAX)) ||
               (c == ASCII_BS) || (c == ASCII_LF) || (c == ASCII_CR);
    endfunction

endpackage

// File: rtl/ascii_stream_arbiter_if.sv
// Source strobes and the consumer-side valid/ready stream of the character
// arbiter, with status outputs.
interface ascii_stream_arbiter_if #(
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DROP_CNT_W = 8
);
    localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [N_SRC-1:0]      src_valid;
    logic [8*N_SRC-1:0]    src_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_data;
    logic [SRC_W-1:0]      out_src;
    logic [CNT_W-1:0]      fifo_count;
    logic                  full;
    logic [DROP_CNT_W-1:0] drop_count;

    modport slave (
        input  src_valid, src_data, out_ready,
        output out_valid, out_data, out_src, fifo_count, full, drop_count
    );

    modport master (
        output src_valid, src_data, out_ready,
        input  out_valid, out_data, out_src, fifo_count, full, drop_count
    );

endinterface

// File: rtl/ascii_stream_arbiter_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head is read combinationally and
// reads as zero while empty. Push when full and pop when empty are ignored.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ascii_stream_arbiter.sv
// Round-robin merge of N_SRC single-cycle character strobes into one FWFT
// character stream. Build option ASCII_FILTER_EN discards non-text bytes at capture.
module ascii_stream_arbiter
    import ascii_pkg::*;
#(
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    ascii_stream_arbiter_if.slave  bus
);

    localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = DROP_CNT_W + 4;

    logic [N_SRC-1:0]      r_pend;
    logic [7:0]            r_hold [N_SRC];
    logic [SRC_W-1:0]      r_rr_ptr;
    logic [DROP_CNT_W-1:0] r_drop_count;

    logic                  w_found;
    logic [SRC_W-1:0]      w_grant;
    int unsigned           w_dist;
    int unsigned           w_best;
    logic                  w_push;
    logic                  w_pop;
    logic [N_SRC-1:0]      w_accept;
    logic [N_SRC-1:0]      w_granted;
    logic [N_SRC-1:0]      w_drop;
    logic [SUM_W-1:0]      w_drop_sum;
    logic [DROP_CNT_W-1:0] w_drop_next;
    fifo_entry_t           w_din;
    fifo_entry_t           w_dout;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_src_unused;

    // Nearest pending source at or after rr_ptr, measured as a cyclic distance.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_dist  = 0;
        w_best  = N_SRC;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            w_dist = (i + N_SRC - 32'(r_rr_ptr)) % N_SRC;
            if (r_pend[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_grant = SRC_W'(i);
                w_found = 1'b1;
            end
        end
    end

    // Count-based full: a pop in the same cycle does not make room for a push.
    assign w_push = w_found && !w_full;
    assign w_pop  = !w_empty && bus.out_ready;

    always_comb begin
        w_din      = '0;
        w_din.src  = 3'(w_grant);
        w_din.data = r_hold[w_grant];
    end

    // A grant frees the holding slot this cycle, so a strobe on the granted
    // source is captured instead of counted as a drop.
    always_comb begin
        w_accept  = '0;
        w_granted = '0;
        w_drop    = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
`ifdef ASCII_FILTER_EN
            w_accept[i] = bus.src_valid[i] && is_accepted_char(bus.src_data[8*i +: 8]);
`else
            w_accept[i] = bus.src_valid[i];
`endif
            w_granted[i] = w_push && (w_grant == SRC_W'(i));
            w_drop[i]    = w_accept[i] && r_pend[i] && !w_granted[i];
        end
    end

    always_comb begin
        w_drop_sum = SUM_W'(r_drop_count);
        for (int unsigned i = 0; i < N_SRC; i++) begin
            w_drop_sum = w_drop_sum + SUM_W'(w_drop[i]);
        end
        if (w_drop_sum > SUM_W'({DROP_CNT_W{1'b1}})) begin
            w_drop_next = '1;
        end else begin
            w_drop_next = w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (w_accept[i] && !w_drop[i]) begin
                r_hold[i] <= bus.src_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend       <= '0;
            r_rr_ptr     <= '0;
            r_drop_count <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (w_accept[i] && !w_drop[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (w_granted[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            if (w_push) begin
                if (w_grant == SRC_W'(N_SRC - 1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_grant + SRC_W'(1);
                end
            end
            r_drop_count <= w_drop_next;
        end
    end

    sync_fifo_fwft #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_src_unused   = &{1'b0, w_dout.src};
    assign bus.out_valid  = !w_empty;
    assign bus.out_data   = w_dout.data;
    assign bus.out_src    = SRC_W'(w_dout.src);
    assign bus.fifo_count = w_count;
    assign bus.full       = w_full;
    assign bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_ascii_stream_arbiter.sv
// Self-checking bench for ascii_stream_arbiter: directed scenarios plus random
// traffic against a queue-based reference of the capture/grant/FIFO rules.
module tb_ascii_stream_arbiter;

    localparam int unsigned N_SRC      = 2;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned DROP_CNT_W = 8;
    localparam int unsigned SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;
    localparam int unsigned VW         = 1 + 8 + SRC_W + CNT_W + 1 + DROP_CNT_W;
    localparam int unsigned DROP_MAX   = (1 << DROP_CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ascii_stream_arbiter_if #(.N_SRC(N_SRC), .DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) bus ();

    ascii_stream_arbiter #(.N_SRC(N_SRC), .DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference state: delivered-order queue, one holding slot per source.
    logic [7:0]  q_data [$];
    int unsigned q_src  [$];
    bit          m_pend [N_SRC];
    logic [7:0]  m_hold [N_SRC];
    int unsigned m_rr    = 0;
    int unsigned m_drops = 0;

    function automatic bit char_ok(input logic [7:0] c);
`ifdef ASCII_FILTER_EN
        return (c >= 8'h20 && c <= 8'h7E) || c == 8'h08 || c == 8'h0A || c == 8'h0D;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_edge(input logic rst, input logic [N_SRC-1:0] sv,
                              input logic [8*N_SRC-1:0] sd, input logic rdy);
        int g;
        bit do_pop;
        logic [7:0] gdata;
        if (rst) begin
            q_data.delete();
            q_src.delete();
            for (int i = 0; i < N_SRC; i++) m_pend[i] = 1'b0;
            m_rr = 0;
            m_drops = 0;
            return;
        end
        do_pop = (q_data.size() != 0) && rdy;
        g = -1;
        gdata = 8'h00;
        if (q_data.size() < DEPTH) begin
            for (int k = 0; k < N_SRC; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % N_SRC]) g = int'((m_rr + k) % N_SRC);
            end
        end
        if (g >= 0) gdata = m_hold[g];
        for (int i = 0; i < N_SRC; i++) begin
            if (g == i) m_pend[i] = 1'b0;
            if (sv[i] && char_ok(sd[8*i +: 8])) begin
                if (m_pend[i]) begin
                    if (m_drops < DROP_MAX) m_drops++;
                end else begin
                    m_hold[i] = sd[8*i +: 8];
                    m_pend[i] = 1'b1;
                end
            end
        end
        if (do_pop) begin
            void'(q_data.pop_front());
            void'(q_src.pop_front());
        end
        if (g >= 0) begin
            q_data.push_back(gdata);
            q_src.push_back(g);
            m_rr = (g + 1) % N_SRC;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [7:0] d;
        logic [SRC_W-1:0] s;
        d = 8'h00;
        s = '0;
        if (q_data.size() != 0) begin
            d = q_data[0];
            s = SRC_W'(q_src[0]);
        end
        return {q_data.size() != 0, d, s, CNT_W'(q_data.size()),
                q_data.size() == DEPTH, DROP_CNT_W'(m_drops)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.out_valid, bus.out_data, bus.out_src, bus.fifo_count, bus.full, bus.drop_count};
    endfunction

    task automatic idle();
        bus.src_valid = '0;
        bus.src_data  = '0;
    endtask

    task automatic step();
        logic r;
        logic [N_SRC-1:0] sv;
        logic [8*N_SRC-1:0] sd;
        logic rdy;
        r   = reset;
        sv  = bus.src_valid;
        sd  = bus.src_data;
        rdy = bus.out_ready;
        @(posedge clk);
        model_edge(r, sv, sd, rdy);
        #1;
    endtask

    task automatic do_reset();
        idle();
        bus.out_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.out_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if (dut_vec() !== '0) $display("FAIL reset_outputs: got %h expected 0", dut_vec());
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        bus.src_valid = 2'b10;
        bus.src_data  = {8'h41, 8'h00};
        step();
        idle();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL single_early: out_valid got %b expected 0", bus.out_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_src, bus.fifo_count} !== {1'b1, 8'h41, 1'b1, 5'd1})
            $display("FAIL single_head: got v=%b d=%h s=%0d c=%0d expected v=1 d=41 s=1 c=1",
                     bus.out_valid, bus.out_data, bus.out_src, bus.fifo_count);
        else n_pass++;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.fifo_count} !== {1'b0, 8'h00, 5'd0})
            $display("FAIL single_drain: got v=%b d=%h c=%0d expected v=0 d=00 c=0",
                     bus.out_valid, bus.out_data, bus.fifo_count);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.out_ready = 1'b1;
        bus.src_valid = 2'b11;
        bus.src_data  = {8'h62, 8'h61};
        step();
        idle();
        step();
        n_checks++;
        if ({bus.out_data, bus.out_src} !== {8'h61, 1'b0})
            $display("FAIL rr_first: got d=%h s=%0d expected d=61 s=0", bus.out_data, bus.out_src);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.out_data, bus.out_src} !== {8'h62, 1'b1})
            $display("FAIL rr_second: got d=%h s=%0d expected d=62 s=1", bus.out_data, bus.out_src);
        else n_pass++;
        step();
        // rr pointer is back at 0: the next simultaneous pair starts with source 0
        bus.src_valid = 2'b11;
        bus.src_data  = {8'h64, 8'h63};
        step();
        idle();
        step();
        n_checks++;
        if ({bus.out_data, bus.out_src} !== {8'h63, 1'b0})
            $display("FAIL rr_wrap: got d=%h s=%0d expected d=63 s=0", bus.out_data, bus.out_src);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL rr_model: got %h expected %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [7:0] got [$];
        int pos;
        bit ordered;
        logic [7:0] last;
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            idle();
            if (c < 20) begin
                bus.src_valid[0]   = 1'b1;
                bus.src_data[7:0]  = 8'h41 + 8'(c);
            end
            if (c == 3) begin
                bus.src_valid[1]   = 1'b1;
                bus.src_data[15:8] = 8'h7A;
            end
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL fair_model cycle %0d: got %h expected %h", c, dut_vec(), exp_vec());
            else n_pass++;
            if (bus.out_valid) got.push_back(bus.out_data);
        end
        pos = -1;
        ordered = 1'b1;
        last = 8'h00;
        foreach (got[i]) begin
            if (got[i] == 8'h7A) pos = i;
            else begin
                if (got[i] <= last) ordered = 1'b0;
                last = got[i];
            end
        end
        n_checks++;
        if (pos < 1 || pos > 4) $display("FAIL fair_latency: 7A position got %0d expected 1..4", pos);
        else n_pass++;
        n_checks++;
        if (!ordered) $display("FAIL fair_order: src0 order got unordered expected ascending");
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] got [$];
        bit ok;
        do_reset();
        for (int k = 0; k < 18; k++) begin
            bus.src_valid = 2'b01;
            bus.src_data  = {8'h00, 8'h30 + 8'(k)};
            step();
            idle();
            step();
        end
        n_checks++;
        if ({bus.fifo_count, bus.full, bus.drop_count} !== {5'd16, 1'b1, 8'd1})
            $display("FAIL overflow_state: got c=%0d f=%b drop=%0d expected c=16 f=1 drop=1",
                     bus.fifo_count, bus.full, bus.drop_count);
        else n_pass++;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 40 && bus.out_valid; n++) begin
            got.push_back(bus.out_data);
            step();
        end
        bus.out_ready = 1'b0;
        ok = (got.size() == 17) && !bus.out_valid;
        foreach (got[i]) if (got[i] !== 8'h30 + 8'(i)) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL overflow_drain: got %0d chars expected 17 in order 30..40", got.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bus.src_valid = 2'b01;
            bus.src_data  = {8'h00, 8'h50 + 8'(k)};
            step();
            idle();
            if (k < 5) step();
        end
        n_checks++;
        if (bus.fifo_count !== 5'd5) $display("FAIL midreset_pre: count got %0d expected 5", bus.fifo_count);
        else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({bus.fifo_count, bus.out_valid, bus.drop_count} !== {5'd0, 1'b0, 8'd0})
            $display("FAIL midreset_post: got c=%0d v=%b drop=%0d expected 0 0 0",
                     bus.fifo_count, bus.out_valid, bus.drop_count);
        else n_pass++;
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL midreset_spurious: out_valid got %b expected 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_filter();
        int unsigned exp_cnt;
        logic [7:0] exp_head;
`ifdef ASCII_FILTER_EN
        exp_cnt = 1;
        exp_head = 8'h0D;
`else
        exp_cnt = 2;
        exp_head = 8'h07;
`endif
        do_reset();
        bus.src_valid = 2'b01;
        bus.src_data  = {8'h00, 8'h07};
        step();
        idle();
        step();
        bus.src_valid = 2'b01;
        bus.src_data  = {8'h00, 8'h0D};
        step();
        idle();
        step();
        step();
        n_checks++;
        if ({bus.fifo_count, bus.out_data, bus.drop_count} !== {CNT_W'(exp_cnt), exp_head, 8'd0})
            $display("FAIL filter: got c=%0d d=%h drop=%0d expected c=%0d d=%h drop=0",
                     bus.fifo_count, bus.out_data, bus.drop_count, exp_cnt, exp_head);
        else n_pass++;
    endtask

    task automatic test_drop_saturation();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            bus.src_valid = 2'b01;
            bus.src_data  = {8'h00, 8'h41};
            step();
        end
        idle();
        step();
        n_checks++;
        if (bus.drop_count !== 8'hFF) $display("FAIL drop_saturate: got %0d expected 255", bus.drop_count);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL drop_model: got %h expected %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.src_valid = N_SRC'($urandom_range(0, 3));
            bus.src_data  = 16'($urandom);
            if (c < 200) bus.out_ready = ($urandom_range(0, 3) == 0);
            else         bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL random cycle %0d: got %h expected %h", c, dut_vec(), exp_vec());
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b0;
        idle();
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_overflow();
        test_reset_mid();
        test_filter();
        test_drop_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
